// File: rtl/rasterizer_writeback_logic_if.sv
// Avalon-MM write-master bus used by the rasterizer writeback stage.
// The master drives address/data/strobes and the slave answers with waitrequest.
interface rasterizer_writeback_logic_if;
    logic [25:0] master_address;
    logic        master_read;
    logic        master_write;
    logic [3:0]  master_byteenable;
    logic [31:0] master_writedata;
    logic        master_waitrequest;

    modport master (
        output master_address,
        output master_read,
        output master_write,
        output master_byteenable,
        output master_writedata,
        input  master_waitrequest
    );

    modport slave (
        input  master_address,
        input  master_read,
        input  master_write,
        input  master_byteenable,
        input  master_writedata,
        output master_waitrequest
    );
endinterface

// File: rtl/rasterizer_writeback_logic.sv
// Final rasterizer stage: buffers fetched pixels, runs the Z test and writes
// colour then depth for each passing pixel over an Avalon-MM master.
module rasterizer_writeback_logic #(
    parameter int FIFO_DEPTH    = 8,
    parameter int AF_MARGIN     = 2,
    parameter int DEPTH_OFFSET  = 4,
    parameter int DEPTH_TEST_EN = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          input_valid,
    input  logic [25:0]                   addr_in,
    input  logic [31:0]                   old_depth_in,
    input  logic [31:0]                   new_depth_in,
    input  logic [23:0]                   color_in,
    input  logic                          done_in,
    output logic                          stall_out,
    rasterizer_writeback_logic_if.master  avm,
    output logic                          done_out,
    output logic [31:0]                   pixels_written,
    output logic [31:0]                   pixels_rejected,
    output logic                          overflow_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(AF_MARGIN);
    localparam logic [25:0]      OFFSET_C = 26'(DEPTH_OFFSET);

    typedef struct packed {
        logic        done;
        logic [23:0] color;
        logic [31:0] new_depth;
        logic [31:0] old_depth;
        logic [25:0] addr;
    } pixel_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR_COLOR = 2'd1,
        S_WR_DEPTH = 2'd2,
        S_RETIRE   = 2'd3
    } state_t;

    pixel_t             mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    state_t             state_r;
    logic [25:0]        addr_r;
    logic [31:0]        depth_r;
    logic [23:0]        color_r;
    logic               done_r;

    logic [25:0]        address_r;
    logic               write_r;
    logic [3:0]         byteenable_r;
    logic [31:0]        writedata_r;
    logic               done_out_r;
    logic [31:0]        written_r;
    logic [31:0]        rejected_r;
    logic               overflow_r;

    pixel_t             in_pixel_s;
    pixel_t             head_s;
    logic               empty_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic               pass_s;
    logic               stall_s;

    // FIFO status, push/pop qualification and the Z-test decision on the head entry
    always_comb begin
        in_pixel_s = '{done: done_in, color: color_in, new_depth: new_depth_in,
                       old_depth: old_depth_in, addr: addr_in};
        head_s     = mem_r[rd_ptr_r];
        empty_s    = (count_r == {CNT_W{1'b0}});
        full_s     = (count_r == DEPTH_C);
        pop_s      = (state_r == S_IDLE) && !empty_s;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_s     = input_valid && (!full_s || pop_s);
        drop_s     = input_valid && full_s && !pop_s;
        if (DEPTH_TEST_EN == 0) begin
            pass_s = 1'b1;
        end else begin
            pass_s = (head_s.new_depth < head_s.old_depth);
        end
        stall_s    = ((DEPTH_C - count_r) <= MARGIN_C);
    end

    // FIFO storage; contents need no reset because count_r gates every read
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_pixel_s;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Writeback FSM with registered Avalon outputs, done pulse and statistics
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            addr_r       <= 26'd0;
            depth_r      <= 32'd0;
            color_r      <= 24'd0;
            done_r       <= 1'b0;
            address_r    <= 26'd0;
            write_r      <= 1'b0;
            byteenable_r <= 4'b0000;
            writedata_r  <= 32'd0;
            done_out_r   <= 1'b0;
            written_r    <= 32'd0;
            rejected_r   <= 32'd0;
            overflow_r   <= 1'b0;
        end else begin
            done_out_r <= 1'b0;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                S_IDLE: begin
                    if (pop_s) begin
                        addr_r  <= head_s.addr;
                        depth_r <= head_s.new_depth;
                        color_r <= head_s.color;
                        done_r  <= head_s.done;
                        if (pass_s) begin
                            state_r <= S_WR_COLOR;
                        end else begin
                            rejected_r <= rejected_r + 32'd1;
                            done_out_r <= head_s.done;
                            state_r    <= S_RETIRE;
                        end
                    end
                end
                S_WR_COLOR: begin
                    // First cycle launches the colour word; later cycles wait for acceptance.
                    if (!write_r) begin
                        write_r      <= 1'b1;
                        address_r    <= addr_r;
                        writedata_r  <= {8'h00, color_r};
                        byteenable_r <= 4'b0111;
                    end else if (!avm.master_waitrequest) begin
                        address_r    <= addr_r + OFFSET_C;
                        writedata_r  <= depth_r;
                        byteenable_r <= 4'b1111;
                        state_r      <= S_WR_DEPTH;
                    end
                end
                S_WR_DEPTH: begin
                    if (!avm.master_waitrequest) begin
                        write_r      <= 1'b0;
                        address_r    <= 26'd0;
                        writedata_r  <= 32'd0;
                        byteenable_r <= 4'b0000;
                        written_r    <= written_r + 32'd1;
                        done_out_r   <= done_r;
                        state_r      <= S_RETIRE;
                    end
                end
                S_RETIRE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    write_r <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_out             = stall_s;
    assign avm.master_address    = address_r;
    assign avm.master_read       = 1'b0;
    assign avm.master_write      = write_r;
    assign avm.master_byteenable = byteenable_r;
    assign avm.master_writedata  = writedata_r;
    assign done_out              = done_out_r;
    assign pixels_written        = written_r;
    assign pixels_rejected       = rejected_r;
    assign overflow_err          = overflow_r;

endmodule
